// File: rtl/mskaes_share_feeder.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_share_feeder
// Brief    : Splits plaintext/key into d bit-interleaved shares, starts the
//            masked AES core and times its run with a watchdog.
//            Define FRESH_MASK_EN for xorshift-based fresh masking.
// Revision : 1.0 - initial release
// ============================================================================
module mskaes_share_feeder #(
    parameter int          d       = 2,
    parameter int          TIMEOUT = 1023,
    parameter logic [63:0] SEED    = 64'hD609C0895E811215
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     plaintext,
    input  logic [127:0]     key,
    input  logic             core_ready,
    output logic             valid_in,
    input  logic             cipher_valid,
    output logic [128*d-1:0] sh_plaintext,
    output logic [128*d-1:0] sh_key,
    output logic             done,
    output logic             timeout,
    output logic [15:0]      latency
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MASK  = 2'd1,
        ISSUE = 2'd2,
        BUSY  = 2'd3
    } state_t;

    localparam logic [15:0] c_TMO = 16'(TIMEOUT);

    state_t           state_q;
    logic             in_ready_q;
    logic             valid_in_q;
    logic             done_q;
    logic             timeout_q;
    logic [15:0]      latency_q;
    logic [15:0]      cnt_q;
    logic [128*d-1:0] sh_pt_q;
    logic [128*d-1:0] sh_key_q;
    logic [128*d-1:0] sh_pt_d;
    logic [128*d-1:0] sh_key_d;
    logic [127:0]     w_src_pt;
    logic [127:0]     w_src_key;

`ifdef FRESH_MASK_EN
    localparam int         c_NWORDS = 4 * (d - 1);
    localparam int         c_MBITS  = 256 * (d - 1);
    localparam int         c_HALF   = 128 * (d - 1);
    localparam logic [7:0] c_MLAST  = 8'(c_NWORDS - 1);

    logic [63:0]        prng_q;
    logic [63:0]        prng_d;
    logic [c_MBITS-1:0] mask_q;
    logic [c_MBITS-1:0] mask_d;
    logic [127:0]       pt_q;
    logic [127:0]       key_q;
    logic [7:0]         mcnt_q;
    logic               w_unused_mask_tail;

    function automatic logic [63:0] xorshift64(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    // Words enter at the top so the first word of a run lands in bits [63:0].
    assign prng_d             = xorshift64(prng_q);
    assign mask_d             = {prng_d, mask_q[c_MBITS-1:64]};
    assign w_unused_mask_tail = ^mask_q[63:0];
    assign w_src_pt           = pt_q;
    assign w_src_key          = key_q;
`else
    logic w_unused_seed;

    assign w_unused_seed = ^SEED;
    assign w_src_pt      = plaintext;
    assign w_src_key     = key;
`endif

    always_comb begin
        sh_pt_d  = '0;
        sh_key_d = '0;
        for (int i = 0; i < 128; i++) begin
            sh_pt_d[d*i]  = w_src_pt[i];
            sh_key_d[d*i] = w_src_key[i];
`ifdef FRESH_MASK_EN
            for (int j = 1; j < d; j++) begin
                sh_pt_d[d*i+j]  = mask_d[(j-1)*128+i];
                sh_key_d[d*i+j] = mask_d[c_HALF+(j-1)*128+i];
                sh_pt_d[d*i]    = sh_pt_d[d*i] ^ mask_d[(j-1)*128+i];
                sh_key_d[d*i]   = sh_key_d[d*i] ^ mask_d[c_HALF+(j-1)*128+i];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            valid_in_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            latency_q  <= 16'd0;
            cnt_q      <= 16'd0;
            sh_pt_q    <= '0;
            sh_key_q   <= '0;
`ifdef FRESH_MASK_EN
            prng_q     <= SEED;
            mask_q     <= '0;
            pt_q       <= '0;
            key_q      <= '0;
            mcnt_q     <= 8'd0;
`endif
        end else begin
            valid_in_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        timeout_q  <= 1'b0;
                        in_ready_q <= 1'b0;
`ifdef FRESH_MASK_EN
                        pt_q       <= plaintext;
                        key_q      <= key;
                        mcnt_q     <= 8'd0;
                        state_q    <= MASK;
`else
                        sh_pt_q    <= sh_pt_d;
                        sh_key_q   <= sh_key_d;
                        state_q    <= ISSUE;
`endif
                    end
                end
`ifdef FRESH_MASK_EN
                MASK: begin
                    prng_q <= prng_d;
                    mask_q <= mask_d;
                    mcnt_q <= mcnt_q + 8'd1;
                    if (mcnt_q == c_MLAST) begin
                        sh_pt_q  <= sh_pt_d;
                        sh_key_q <= sh_key_d;
                        state_q  <= ISSUE;
                    end
                end
`endif
                ISSUE: begin
                    if (core_ready) begin
                        state_q    <= BUSY;
                        valid_in_q <= 1'b1;
                        cnt_q      <= 16'd1;
                    end
                end
                BUSY: begin
                    // A completion in the watchdog's final cycle still counts as done.
                    if (cipher_valid) begin
                        done_q     <= 1'b1;
                        latency_q  <= cnt_q;
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end else if (cnt_q == c_TMO) begin
                        timeout_q  <= 1'b1;
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign valid_in     = valid_in_q;
    assign done         = done_q;
    assign timeout      = timeout_q;
    assign latency      = latency_q;
    assign sh_plaintext = sh_pt_q;
    assign sh_key       = sh_key_q;

endmodule
`default_nettype wire
